// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: core request/response port and word-wide memory bus for lsu_ctrl
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [2:0] req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_b_en;
  logic mem_w_en;
  logic [31:0] mem_rdata;
  logic mem_stall;
  logic mem_error;
  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata, mem_stall, mem_error,
    input req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_b_en, mem_w_en
  );
  modport slave (
    input req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata, mem_stall, mem_error,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_wdata, mem_b_en, mem_w_en
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RISC-V load/store controller between the core request port and a word-wide memory
module lsu_ctrl #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 32
) (
  input logic gclk,
  input logic reset,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [2:0] cnt;
  logic err;
  logic wr;
  logic [2:0] size;
  logic [1:0] lane;
  logic bad;
  logic err_n;
  logic [3:0] st_ben;
  logic [31:0] st_data;
  logic [31:0] sh;
  logic [31:0] ld_data;

  // decode the incoming request and shape load data from the current memory word
  always_comb begin
    bad = bus.req_size == 3'b011 || bus.req_size[2:1] == 2'b11 ||
          (bus.req_size[1:0] == 2'b01 && bus.req_addr[0]) ||
          (bus.req_size == 3'b010 && bus.req_addr[1:0] != 2'b00);
    st_ben = bus.req_size[1:0] == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
             bus.req_size[1:0] == 2'b01 ? 4'b0011 << {bus.req_addr[1], 1'b0} : 4'b1111;
    st_data = bus.req_size[1:0] == 2'b00 ? {4{bus.req_wdata[7:0]}} :
              bus.req_size[1:0] == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    sh = bus.mem_rdata >> {lane, 3'b000};
    ld_data = size[1:0] == 2'b00 ? {{24{~size[2] & sh[7]}}, sh[7:0]} :
              size[1:0] == 2'b01 ? {{16{~size[2] & sh[15]}}, sh[15:0]} : sh;
    err_n = err | bus.mem_error;
  end

  // request FSM with registered core and memory outputs; a stall freezes ISSUE/WAIT
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      wr <= 1'b0;
      size <= '0;
      lane <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_b_en <= '0;
      bus.mem_w_en <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          wr <= bus.req_write;
          size <= bus.req_size;
          lane <= bus.req_addr[1:0];
          err <= 1'b0;
          cnt <= '0;
          bus.req_ready <= 1'b0;
          if (bad) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= 1'b1;
          end else begin
            state <= ISSUE;
            bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            bus.mem_wdata <= bus.req_write ? st_data : '0;
            bus.mem_b_en <= bus.req_write ? st_ben : 4'b1111;
            bus.mem_w_en <= bus.req_write;
          end
        end
        ISSUE: begin
          err <= err_n;
          if (!bus.mem_stall && wr) begin
            state <= RESP;
            bus.mem_b_en <= '0;
            bus.mem_w_en <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= err_n;
          end else if (!bus.mem_stall) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          err <= err_n;
          if (!bus.mem_stall && cnt == 3'(RD_LAT - 1)) begin
            state <= RESP;
            bus.mem_b_en <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= err_n;
            bus.rsp_rdata <= err_n ? '0 : ld_data;
          end else if (!bus.mem_stall) begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl with a byte-lane memory model
module tb_lsu_ctrl;
  typedef struct {
    logic [31:0] rd;
    logic err;
    int lat;
  } exp_t;

  logic gclk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int asserts = 0;
  int fails = 0;
  exp_t q[$];
  logic [31:0] mem [64];
  logic [31:0] iss_addr, iss_wd;
  logic [3:0] iss_ben;
  logic iss_wen, any_ben, held;

  lsu_ctrl_if #(.ADDR_W(32)) b();
  lsu_ctrl #(.RD_LAT(2), .ADDR_W(32)) dut (.gclk(gclk), .reset(reset), .bus(b.slave));

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;
  always @(posedge gclk)
    if (b.mem_w_en && !b.mem_stall)
      for (int i = 0; i < 4; i++)
        if (b.mem_b_en[i]) mem[b.mem_addr[7:2]][i*8 +: 8] <= b.mem_wdata[i*8 +: 8];
  assign b.mem_rdata = mem[b.mem_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                        input int elat, input int st, input int ea);
    exp_t e;
    bit got;
    int h, lat;
    logic [31:0] ord;
    logic oerr;
    b.req_valid = 1'b1;
    b.req_write = w;
    b.req_size = sz;
    b.req_addr = a;
    b.req_wdata = wd;
    q.push_back('{erd, eerr, elat});
    @(posedge gclk);
    #1;
    b.req_valid = 1'b0;
    h = cyc;
    got = 0; any_ben = 0; held = 1; lat = 0; ord = '0; oerr = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge gclk);
      if (i == 0) begin
        iss_addr = b.mem_addr; iss_wd = b.mem_wdata; iss_ben = b.mem_b_en; iss_wen = b.mem_w_en;
      end
      any_ben |= |b.mem_b_en;
      if (b.rsp_valid) begin
        got = 1; lat = cyc - h + 1; ord = b.rsp_rdata; oerr = b.rsp_error;
      end else begin
        held &= (b.mem_addr === iss_addr && b.mem_b_en === iss_ben && b.mem_w_en === iss_wen);
      end
      b.mem_stall = (i >= st && i < st + 3);
      b.mem_error = (i == ea);
    end
    b.mem_stall = 1'b0;
    b.mem_error = 1'b0;
    chk({tag, " response seen"}, 32'(got), 32'd1);
    e = q.pop_front();
    if (got) begin
      chk({tag, " rsp_rdata"}, ord, e.rd);
      chk({tag, " rsp_error"}, 32'(oerr), 32'(e.err));
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    end
    @(negedge gclk);
    chk({tag, " strobe one cycle"}, 32'(b.rsp_valid), 32'd0);
    chk({tag, " rdata idle zero"}, b.rsp_rdata, 32'd0);
    chk({tag, " ready back"}, 32'(b.req_ready), 32'd1);
  endtask

  initial begin
    b.req_valid = 1'b0; b.req_write = 1'b0; b.req_size = '0; b.req_addr = '0; b.req_wdata = '0;
    b.mem_stall = 1'b0; b.mem_error = 1'b0;
    repeat (2) @(negedge gclk);
    chk("reset req_ready", 32'(b.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(b.rsp_valid), 32'd0);
    chk("reset rsp_rdata", b.rsp_rdata, 32'd0);
    chk("reset rsp_error", 32'(b.rsp_error), 32'd0);
    chk("reset mem_addr", b.mem_addr, 32'd0);
    chk("reset mem_wdata", b.mem_wdata, 32'd0);
    chk("reset mem_b_en", 32'(b.mem_b_en), 32'd0);
    chk("reset mem_w_en", 32'(b.mem_w_en), 32'd0);
    reset = 1'b0;

    do_req("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 99, 99);
    chk("SW mem_addr", iss_addr, 32'h10);
    chk("SW b_en", 32'(iss_ben), 32'hF);
    chk("SW w_en", 32'(iss_wen), 32'd1);
    chk("SW wdata", iss_wd, 32'hDEADBEEF);

    do_req("SB 0x13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 2, 99, 99);
    chk("SB mem_addr", iss_addr, 32'h10);
    chk("SB b_en", 32'(iss_ben), 32'h8);
    chk("SB wdata", iss_wd, 32'hA5A5A5A5);

    do_req("LB 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 4, 99, 99);
    chk("LB b_en", 32'(iss_ben), 32'hF);
    chk("LB w_en", 32'(iss_wen), 32'd0);
    do_req("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 4, 99, 99);

    do_req("SW 0x20", 1'b1, 3'b010, 32'h20, 32'h80017FFF, 32'h0, 1'b0, 2, 99, 99);
    do_req("LH 0x22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 4, 99, 99);
    do_req("LHU 0x22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 4, 99, 99);

    do_req("SH 0x22", 1'b1, 3'b001, 32'h22, 32'h00001234, 32'h0, 1'b0, 2, 99, 99);
    chk("SH b_en", 32'(iss_ben), 32'hC);
    chk("SH wdata", iss_wd, 32'h12341234);
    do_req("LW 0x20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12347FFF, 1'b0, 4, 99, 99);

    do_req("LW misaligned", 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1, 99, 99);
    chk("LW misaligned no b_en", 32'(any_ben), 32'd0);
    do_req("funct3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 99, 99);
    chk("funct3 011 no b_en", 32'(any_ben), 32'd0);

    do_req("LW stalled", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 7, 1, 99);
    chk("LW stalled mem held", 32'(held), 32'd1);
    do_req("LW mem_error", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b1, 4, 99, 1);

    b.req_valid = 1'b1; b.req_write = 1'b0; b.req_size = 3'b010; b.req_addr = 32'h10;
    @(posedge gclk);
    #1;
    b.req_valid = 1'b0;
    repeat (2) @(negedge gclk);
    chk("pre-reset load b_en", 32'(b.mem_b_en), 32'hF);
    reset = 1'b1;
    #1;
    chk("mid reset req_ready", 32'(b.req_ready), 32'd1);
    chk("mid reset rsp_valid", 32'(b.rsp_valid), 32'd0);
    chk("mid reset mem_addr", b.mem_addr, 32'd0);
    chk("mid reset mem_b_en", 32'(b.mem_b_en), 32'd0);
    chk("mid reset mem_w_en", 32'(b.mem_w_en), 32'd0);
    @(negedge gclk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge gclk);
      chk("dropped load no rsp", 32'(b.rsp_valid), 32'd0);
    end
    do_req("SW after reset", 1'b1, 3'b010, 32'h30, 32'h11223344, 32'h0, 1'b0, 2, 99, 99);
    do_req("LW 0x30", 1'b0, 3'b010, 32'h30, 32'h0, 32'h11223344, 1'b0, 4, 99, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter RD_LAT, default 2, cycles from end of ISSUE to the mem_rdata sample point for loads (legal values 1..7).
REQ-002 Parameter ADDR_W, default 32, address width for core and memory sides.
REQ-003 Port gclk  input  1  single global clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  core presents a load/store request.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_write  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 Port req_addr  input  ADDR_W  byte address.
REQ-010 Port req_wdata  input  32  store data, right-aligned.
REQ-011 Port rsp_valid  output  1  one-cycle response strobe.
REQ-012 Port rsp_rdata  output  32  aligned, extended load data (0 for stores).
REQ-013 Port rsp_error  output  1  access faulted; qualified by rsp_valid.
REQ-014 Port mem_addr  output  ADDR_W  word-aligned memory address.
REQ-015 Port mem_wdata  output  32  lane-replicated store data.
REQ-016 Port mem_b_en  output  4  byte-lane enables.
REQ-017 Port mem_w_en  output  1  memory write enable.
REQ-018 Port mem_rdata  input  32  memory read data.
REQ-019 Port mem_stall  input  1  memory not ready; hold the current access.
REQ-020 Port mem_error  input  1  memory reports out-of-range access.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a handshake (req_valid & req_ready) captures write, size, addr and wdata and moves to ISSUE.
REQ-023 Misaligned requests (H/HU with addr[0]=1, W with addr[1:0]!=0) and illegal funct3 (011, 110, 111) SHALL skip memory and go IDLE->RESP with rsp_error=1.
REQ-024 mem_addr SHALL equal the captured addr with bits [1:0] cleared, held stable from ISSUE through WAIT.
REQ-025 Store byte enables: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111.
REQ-026 Store data: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-027 Stores SHALL drive mem_w_en=1 and the computed mem_b_en in ISSUE only, then go ISSUE->RESP.
REQ-028 Loads SHALL drive mem_b_en=1111 and mem_w_en=0 in ISSUE and every WAIT cycle, then go ISSUE->WAIT.
REQ-029 WAIT SHALL count RD_LAT non-stalled cycles, sample mem_rdata on the last one, and go to RESP.
REQ-030 While mem_stall=1, ISSUE and WAIT SHALL hold state, counter and all mem_* outputs unchanged.
REQ-031 Loads SHALL extract the byte/halfword lane from addr[1:0], sign-extend B/H and zero-extend BU/HU.
REQ-032 mem_error sampled 1 in any ISSUE or WAIT cycle SHALL set a sticky flag reported as rsp_error; rsp_rdata SHALL then be 0.
REQ-033 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; there is no response backpressure.
REQ-034 Outside ISSUE/WAIT, mem_b_en and mem_w_en SHALL be 0; rsp_rdata and rsp_error SHALL be 0 when rsp_valid=0.
REQ-035 Latency: a store completes 2 cycles after handshake; a load completes RD_LAT+2 cycles after handshake, plus any stall cycles.

Reset
REQ-036 Asserting reset SHALL immediately force IDLE and clear the counter, error flag and captured request.
REQ-037 Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, mem_addr=0, mem_wdata=0, mem_b_en=0, mem_w_en=0.
REQ-038 A request in flight at reset SHALL be dropped with no rsp_valid; the first request after reset is accepted on the first edge with reset low.

Verification
REQ-039 SW addr 0x10, data 0xDEADBEEF -> ISSUE cycle has mem_addr 0x10, b_en 1111, w_en 1; rsp_valid 2 cycles after handshake, rsp_error 0.
REQ-040 SB addr 0x13, data 0x000000A5 -> b_en 1000, mem_wdata 0xA5A5A5A5; then LB 0x13 -> rsp_rdata 0xFFFFFFA5, and LBU 0x13 -> 0x000000A5.
REQ-041 LH addr 0x22 with memory word 0x80017FFF -> rsp_rdata 0xFFFF8001; LHU same -> 0x00008001; rsp_valid RD_LAT+2 cycles after handshake.
REQ-042 LW addr 0x06, and funct3 011 -> no mem_b_en activity, rsp_valid on the next cycle with rsp_error 1.
REQ-043 LW with mem_stall high 3 cycles during WAIT -> mem_* held constant, rsp_valid delayed exactly 3 cycles; mem_error pulse in WAIT -> rsp_error 1, rsp_rdata 0.
REQ-044 Reset asserted during WAIT -> outputs at reset values immediately, no rsp_valid; a new SW accepted after release completes normally.
